// File: rtl/rect_cmd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer_pkg
//   Shared definitions for the rectangle command path: command field widths,
//   the packed command record carried through the FIFO, the sequencer state
//   encoding, and a helper that identifies degenerate (zero-area) commands.
//   The renderer and the scene logic import the same definitions.
// -----------------------------------------------------------------------------
package rect_cmd_sequencer_pkg;

  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int W_W   = 9;
  localparam int H_W   = 8;
  localparam int COL_W = 3;

  // Field order matches the on-wire command word {x,y,w,h,back,border,bcol}.
  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [W_W-1:0]   w;
    logic [H_W-1:0]   h;
    logic [COL_W-1:0] back;
    logic             border;
    logic [COL_W-1:0] bcol;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);  // 41

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARM     = 3'd2,
    ST_DRAW    = 3'd3,
    ST_RELEASE = 3'd4
  } state_e;

  // A rectangle with no width or no height draws nothing.
  function automatic logic cmd_is_empty(input cmd_t c);
    return (c.w == '0) || (c.h == '0);
  endfunction

endpackage

// File: rtl/rect_cmd_sequencer_if.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer_if
//   Bundles the producer command channel (valid/ready plus attributes) and the
//   renderer channel (enable/done plus registered attributes).
//   slave  : the sequencer side (consumes commands, drives the renderer)
//   master : the environment side (produces commands, acts as renderer)
// -----------------------------------------------------------------------------
interface rect_cmd_sequencer_if;
  import rect_cmd_sequencer_pkg::*;

  // producer -> sequencer
  logic             cmd_valid;
  logic             cmd_ready;
  logic [X_W-1:0]   cmd_x;
  logic [Y_W-1:0]   cmd_y;
  logic [W_W-1:0]   cmd_w;
  logic [H_W-1:0]   cmd_h;
  logic [COL_W-1:0] cmd_back;
  logic             cmd_border;
  logic [COL_W-1:0] cmd_bcol;

  // sequencer -> renderer
  logic             rect_enable;
  logic [X_W-1:0]   rect_x;
  logic [Y_W-1:0]   rect_y;
  logic [W_W-1:0]   rect_w;
  logic [H_W-1:0]   rect_h;
  logic [COL_W-1:0] rect_back;
  logic             rect_border;
  logic [COL_W-1:0] rect_bcol;
  logic             rect_done;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_bcol,
    output cmd_ready,
    output rect_enable, rect_x, rect_y, rect_w, rect_h, rect_back, rect_border, rect_bcol,
    input  rect_done
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_back, cmd_border, cmd_bcol,
    input  cmd_ready,
    input  rect_enable, rect_x, rect_y, rect_w, rect_h, rect_back, rect_border, rect_bcol,
    output rect_done
  );

endinterface

// File: rtl/rect_cmd_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer_cmd_fifo
//   DEPTH x DATA_W command FIFO with first-word fall-through read port.
//   clk, resetn  : clock, async active-low reset (pointers/count only)
//   flush        : sync clear; overrides push and pop in the same cycle
//   push/wr_data : write request and data (ignored when full)
//   pop          : advance read pointer (ignored when empty)
//   rd_data      : current head entry
//   count        : occupancy 0..DEPTH
//   full/empty   : occupancy flags
// -----------------------------------------------------------------------------
module rect_cmd_sequencer_cmd_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 41
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr_q];

  // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + (ADDR_W+1)'(1);
      else if (pop_ok && !push_ok) count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only entries between the pointers are visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/rect_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// rect_cmd_sequencer
//   Buffers rectangle draw commands and issues them one at a time to the
//   rectangle renderer over its enable/done handshake. Attributes are held
//   stable while enable is high and enable drops for at least one cycle
//   between rectangles.
//   clk          : system clock
//   resetn       : async active-low reset
//   flush        : sync; empties the queue and aborts the current draw
//   bus (slave)  : producer command channel and renderer channel
//   busy         : sequencer not idle
//   count        : queued command count
//   timeout_err  : sticky watchdog abort flag, cleared by reset or flush
// -----------------------------------------------------------------------------
module rect_cmd_sequencer
  import rect_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int DONE_MASK = 2,
  parameter int TIMEOUT   = 131072
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  rect_cmd_sequencer_if.slave  bus,
  output logic                 busy,
  output logic [ADDR_W:0]      count,
  output logic                 timeout_err
);

  localparam int MASK_W = (DONE_MASK > 1) ? $clog2(DONE_MASK) : 1;
  localparam int WD_W   = (TIMEOUT   > 1) ? $clog2(TIMEOUT)   : 1;

  state_e            state_q, state_d;
  logic [MASK_W-1:0] mask_q, mask_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_q, err_d;
  logic              en_q, en_d;
  cmd_t              rect_q;

  cmd_t              cmd_in, head;
  logic [CMD_W-1:0]  head_raw;
  logic              fifo_full, fifo_empty;
  logic              pop, load;

  assign cmd_in = {bus.cmd_x, bus.cmd_y, bus.cmd_w, bus.cmd_h,
                   bus.cmd_back, bus.cmd_border, bus.cmd_bcol};
  assign head   = cmd_t'(head_raw);

  rect_cmd_sequencer_cmd_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (flush),
    .push    (bus.cmd_valid),
    .pop     (pop),
    .wr_data (cmd_in),
    .rd_data (head_raw),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    wd_d    = wd_q;
    err_d   = err_q;
    pop     = 1'b0;
    load    = 1'b0;
    if (flush) begin
      // An active draw still gets its one-cycle enable-low release.
      state_d = en_q ? ST_RELEASE : ST_IDLE;
      mask_d  = '0;
      wd_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_d = ST_LOAD;
        end
        ST_LOAD: begin
          pop     = 1'b1;
          load    = 1'b1;
          mask_d  = '0;
          wd_d    = '0;
          state_d = cmd_is_empty(head) ? ST_IDLE : ST_ARM;
        end
        ST_ARM: begin
          // A done left over from the previous rectangle is ignored here.
          if (mask_q == MASK_W'(DONE_MASK - 1)) state_d = ST_DRAW;
          else                                   mask_d  = mask_q + MASK_W'(1);
        end
        ST_DRAW: begin
          if (bus.rect_done) begin
            state_d = ST_RELEASE;
          end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_d = ST_RELEASE;
            err_d   = 1'b1;
          end else begin
            wd_d = wd_q + WD_W'(1);
          end
        end
        ST_RELEASE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
    // Enable is registered from the next state so it aligns with ARM/DRAW.
    en_d = (state_d == ST_ARM) || (state_d == ST_DRAW);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      rect_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      en_q    <= en_d;
      if (load) rect_q <= head;
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.rect_enable = en_q;
  assign bus.rect_x      = rect_q.x;
  assign bus.rect_y      = rect_q.y;
  assign bus.rect_w      = rect_q.w;
  assign bus.rect_h      = rect_q.h;
  assign bus.rect_back   = rect_q.back;
  assign bus.rect_border = rect_q.border;
  assign bus.rect_bcol   = rect_q.bcol;
  assign busy            = (state_q != ST_IDLE);
  assign timeout_err     = err_q;

endmodule
